// File: rtl/vrsn_roll_sched.sv
// Version-rolling job scheduler: rolls a version bit field over NUM_CH midstate channels per round.
// Build with `define VRSN_ROLL_RESUME_EN to add the resume input (continue rolling after a find).

module vrsn_roll_lane #(
   parameter int K        = 0,
   parameter int ROLL_LSB = 13,
   parameter int ROLL_MSB = 28
) (
   input  logic [31:0]                  base_nat,
   input  logic [ROLL_MSB-ROLL_LSB+1:0] f,
   output logic                         en,
   output logic [31:0]                  vrsn
);
   localparam int W  = ROLL_MSB - ROLL_LSB + 1;
   localparam int W1 = W + 1;

   logic [W:0]  cand;
   logic [31:0] nat;

   // carry into bit W means the field would wrap, so the lane sits out
   assign cand = f + W1'(K);
   assign en   = ~cand[W];

   always_comb begin
      nat = base_nat;
      nat[ROLL_MSB:ROLL_LSB] = cand[W-1:0];
   end

   assign vrsn = en ? {nat[7:0], nat[15:8], nat[23:16], nat[31:24]} : 32'h0;
endmodule

module vrsn_roll_sched #(
   parameter int NUM_CH   = 3,
   parameter int ROLL_LSB = 13,
   parameter int ROLL_MSB = 28,
   parameter int CHW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 hdr_load,
   input  logic [31:0]          base_vrsn,
   output logic                 ms_start,
   output logic [NUM_CH-1:0]    ms_ch_en,
   output logic [32*NUM_CH-1:0] ms_vrsn,
   input  logic [NUM_CH-1:0]    ms_done,
   output logic                 core_start,
   input  logic                 core_done,
   input  logic                 core_found,
   input  logic [CHW-1:0]       core_found_ch,
   output logic                 found_valid,
   output logic [31:0]          found_vrsn,
   output logic                 ovf_flg,
   output logic                 busy,
   output logic [31:0]          round_cnt
`ifdef VRSN_ROLL_RESUME_EN
   ,
   input  logic                 resume
`endif
);
   localparam int W  = ROLL_MSB - ROLL_LSB + 1;
   localparam int W1 = W + 1;

   typedef enum logic [2:0] {IDLE, GEN, MS_RUN, CORE_RUN, FOUND, OVF} state_t;
   state_t state, state_nxt;

   logic [31:0]             base_nat, load_nat, hit_vrsn;
   logic [W:0]              f;
   logic [NUM_CH-1:0]       lane_en;
   logic [NUM_CH-1:0][31:0] lane_vrsn, ms_vrsn_q;
   logic resume_go, ms_all_done, core_evt, hit;
   logic gen_go, start_ms, start_core, found_go, adv;

   assign load_nat = {base_vrsn[7:0], base_vrsn[15:8], base_vrsn[23:16], base_vrsn[31:24]};
   assign ms_vrsn  = ms_vrsn_q;

`ifdef VRSN_ROLL_RESUME_EN
   assign resume_go = resume;
`else
   assign resume_go = 1'b0;
`endif

   generate
      for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
         vrsn_roll_lane #(.K(k), .ROLL_LSB(ROLL_LSB), .ROLL_MSB(ROLL_MSB)) u_lane (
            .base_nat (base_nat),
            .f        (f),
            .en       (lane_en[k]),
            .vrsn     (lane_vrsn[k])
         );
      end
   endgenerate

   // done levels seen during a launch pulse belong to the previous round
   assign ms_all_done = ~ms_start && ((ms_done & ms_ch_en) == ms_ch_en);
   assign core_evt    = core_done && ~core_start;

   always_comb begin
      hit      = 1'b0;
      hit_vrsn = 32'h0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (core_found && (core_found_ch == CHW'(k)) && ms_ch_en[k]) begin
            hit      = 1'b1;
            hit_vrsn = ms_vrsn_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (hdr_load) state_nxt = GEN;
      else begin
         case (state)
            GEN:      state_nxt = (|lane_en) ? MS_RUN : OVF;
            MS_RUN:   if (ms_all_done) state_nxt = CORE_RUN;
            CORE_RUN: if (core_evt) state_nxt = hit ? FOUND : GEN;
            FOUND:    if (resume_go) state_nxt = GEN;
            default:  state_nxt = state;
         endcase
      end
   end

   always_comb begin
      busy       = (state == GEN) || (state == MS_RUN) || (state == CORE_RUN);
      gen_go     = (state == GEN) && ~hdr_load;
      start_ms   = gen_go && (|lane_en);
      start_core = (state == MS_RUN) && ms_all_done && ~hdr_load;
      found_go   = (state == CORE_RUN) && core_evt && hit && ~hdr_load;
      adv        = ~hdr_load && (((state == CORE_RUN) && core_evt && ~hit) ||
                                 ((state == FOUND) && resume_go));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ms_start    <= 1'b0;
         core_start  <= 1'b0;
         ms_ch_en    <= '0;
         ms_vrsn_q   <= '0;
         found_valid <= 1'b0;
         found_vrsn  <= 32'h0;
         ovf_flg     <= 1'b0;
         round_cnt   <= 32'h0;
         base_nat    <= 32'h0;
         f           <= '0;
      end else begin
         ms_start   <= start_ms;
         core_start <= start_core;
         if (hdr_load) begin
            base_nat    <= load_nat;
            f           <= {1'b0, load_nat[ROLL_MSB:ROLL_LSB]};
            round_cnt   <= 32'h0;
            found_valid <= 1'b0;
            ovf_flg     <= 1'b0;
         end else begin
            if (gen_go) begin
               ms_ch_en  <= lane_en;
               ms_vrsn_q <= lane_vrsn;
               if (~|lane_en) ovf_flg <= 1'b1;
            end
            if (found_go) begin
               found_valid <= 1'b1;
               found_vrsn  <= hit_vrsn;
            end
            if (adv) begin
               f           <= f + W1'(NUM_CH);
               found_valid <= 1'b0;
               if (round_cnt != 32'hFFFF_FFFF) round_cnt <= round_cnt + 32'd1;
            end
         end
      end
   end
endmodule

// File: doc/vrsn_roll_sched.md
Name: vrsn_roll_sched

Overview:
- Parametrised version-rolling job scheduler for the mining engine; replaces the fixed 3-way version generation and midstate sequencing.
- Takes the header version word and rolls a configurable bit field across NUM_CH candidates per round.
- Dispatches the candidates to NUM_CH midstate units, then starts the core and reacts to its result.
- Reports the winning version, or flags overflow when the rolling field is exhausted.

Parameters:
- NUM_CH, 3, number of candidate versions / midstate channels per round (1..8).
- ROLL_LSB, 13, lowest bit of the rolling field in native-order version.
- ROLL_MSB, 28, highest bit of the rolling field; field width W = ROLL_MSB-ROLL_LSB+1.
- CHW, $clog2(NUM_CH) (min 1), width of channel index.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- hdr_load  in  1  pulse: new header; latch base_vrsn and start rolling.
- base_vrsn  in  32  version word in header (little-endian byte) order.
- ms_start  out  1  one-cycle pulse launching the midstate units.
- ms_ch_en  out  NUM_CH  per-channel enable for the current round.
- ms_vrsn  out  32*NUM_CH  candidate k in header byte order at bits [32k+31:32k]; 0 when disabled.
- ms_done  in  NUM_CH  per-channel sticky done level, cleared by the units on ms_start.
- core_start  out  1  one-cycle pulse starting the core on the latched midstates.
- core_done  in  1  pulse: core finished its nonce/time sweep.
- core_found  in  1  qualifies core_done: block found.
- core_found_ch  in  CHW  winning channel, valid with core_found.
- found_valid  out  1  sticky: block found.
- found_vrsn  out  32  winning version in header byte order.
- ovf_flg  out  1  sticky: rolling field exhausted.
- busy  out  1  high in any state except IDLE/FOUND/OVF.
- round_cnt  out  32  completed rounds since hdr_load, saturating.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, internal base field = 0.
- Byte swap: native = {v[7:0],v[15:8],v[23:16],v[31:24]}; outputs are swapped back.
- Field: f = native[ROLL_MSB:ROLL_LSB]; candidate k = f + k computed at W+1 bits.
- Candidate k is enabled iff f+k <= 2^W-1 (no wrap).
- Enabled candidate value: native with field replaced by f+k, bits outside the field unchanged.
- FSM states: IDLE, GEN, MS_RUN, CORE_RUN, FOUND, OVF.
- IDLE: hdr_load -> latch base, round_cnt = 0, clear found_valid/ovf_flg, go to GEN next cycle.
- GEN (1 cycle): compute ms_ch_en and ms_vrsn.
  - No channel enabled -> OVF, ovf_flg = 1.
  - Otherwise pulse ms_start and go to MS_RUN.
  - ms_vrsn/ms_ch_en stay stable until the next GEN.
- MS_RUN: wait until (ms_done & ms_ch_en) == ms_ch_en, ignoring ms_done on disabled channels; then pulse core_start and go to CORE_RUN. Latency ms_done-complete -> core_start = 1 cycle.
- CORE_RUN, on core_done:
  - core_found=1 and core_found_ch enabled -> found_vrsn = ms_vrsn[ch], found_valid = 1, go to FOUND.
  - core_found=1 with a disabled or out-of-range ch -> treat as not found.
  - Not found -> f += NUM_CH (W+1 bits), round_cnt++ (saturate at 0xFFFFFFFF), go to GEN.
- FOUND, OVF: hold outputs; only hdr_load or rst leaves.
- hdr_load in any state (including mid MS_RUN/CORE_RUN): abort, reload, go to GEN next cycle. No ms_start/core_start on the load cycle. Stale core_done/ms_done from the aborted round is ignored until the next ms_start.
- rst has priority over hdr_load.
- ms_start and core_start are never high in the same cycle.

Optional Feature:
- Macro VRSN_ROLL_RESUME_EN.
- Defined: adds input port resume (1 bit). In FOUND, a resume pulse clears found_valid, advances f += NUM_CH, increments round_cnt and goes to GEN, so rolling continues after a find.
- Undefined: no resume port; FOUND is terminal until hdr_load/rst.

Test Plan:
- Reset, then hdr_load with base_vrsn=0x00000020 -> GEN.
  - Required: ms_ch_en=3'b111; ms_vrsn ch0=0x00000020, ch1=0x00200020, ch2=0x00400020.
  - Required: ms_start exactly one cycle after GEN.
- Raise ms_done in order 001, 011, 111 -> core_start pulses once, 1 cycle after ms_done=111. Then core_done with core_found=0 -> next GEN shows ch0=0x00600020, round_cnt=1.
- base_vrsn=0x00C0FF3F (native 0x3FFFC000, f=0xFFFE) -> ms_ch_en=3'b011, ch2 ms_vrsn=0. core_found=1 with core_found_ch=1 -> found_valid=1, found_vrsn=0x00E0FF3F, busy=0.
- Same base, core_done not found -> next GEN has no enabled channel -> ovf_flg=1, no ms_start, busy=0.
- hdr_load during CORE_RUN with a new base 0x00000020 -> GEN next cycle, round_cnt=0. A core_done pulse 2 cycles later is ignored (no state change, found_valid stays 0).
- With VRSN_ROLL_RESUME_EN defined: from FOUND (base 0x00000020, round 0), pulse resume -> found_valid=0, GEN with ch0=0x00600020, round_cnt=1.
